// File: rtl/uart_rx_cfg_pkg.sv
// Shared UART definitions: receiver state encoding and parity-mode constants.
// Intended to be reused by the companion transmitter.
package uart_rx_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_t;

    localparam logic PARITY_MODE_EVEN = 1'b0;
    localparam logic PARITY_MODE_ODD  = 1'b1;

    // XOR of data and parity bit must equal 0 for even parity and 1 for odd parity.
    function automatic logic parity_mismatch(input logic xor_all, input logic odd_mode);
        return xor_all != odd_mode;
    endfunction

endpackage

// File: rtl/uart_rx_cfg_sync.sv
// Metastability synchroniser for the asynchronous rx line.
// Flops reset to 1 so an idle (high) line is seen during and right after reset.
module uart_rx_cfg_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] ff_q;

    // Shift the raw line through the flop chain, one stage per clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ff_q <= '1;
        end else begin
            ff_q <= {ff_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: oversampled start/data/parity/stop sampling,
// false-start rejection and parity/framing/break reporting per frame.
module uart_rx_cfg
    import uart_rx_cfg_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_doneTick,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          ODD_MODE  = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;
    localparam bit            HAS_PAR   = (PARITY_EN != 0);

    logic rxs;

    rx_state_t              state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   buf_q, buf_d;
    logic                   par_bit_q, par_bit_d;
    logic                   par_err_q, par_err_d;
    logic                   stop_bad_q, stop_bad_d;   // some earlier stop sample was 0
    logic                   stop_all0_q, stop_all0_d; // every stop sample so far was 0
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   done_q, done_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   brk_q, brk_d;

    logic                   stop_bad_now;
    logic                   stop_all0_now;

    uart_rx_cfg_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (clk),
        .rst_ni(rst_n),
        .d_i   (rx),
        .q_o   (rxs)
    );

    assign stop_bad_now  = stop_bad_q | ~rxs;
    assign stop_all0_now = stop_all0_q & ~rxs;

    // Next-state logic: FSM advances only on s_tick; the done pulse self-clears every clock.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        buf_d       = buf_q;
        par_bit_d   = par_bit_q;
        par_err_d   = par_err_q;
        stop_bad_d  = stop_bad_q;
        stop_all0_d = stop_all0_q;
        data_d      = data_q;
        done_d      = 1'b0;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        brk_d       = brk_q;

        if (s_tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    tick_d = '0;
                    if (!rxs) begin
                        state_d = ST_START;
                    end
                end

                ST_START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d = '0;
                        if (rxs) begin
                            // Line went back high before mid start bit: glitch, not a frame.
                            state_d = ST_IDLE;
                        end else begin
                            bit_d   = '0;
                            state_d = ST_DATA;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (tick_q == TICK_END) begin
                        tick_d = '0;
                        buf_d  = {rxs, buf_q[DATA_BITS-1:1]};
                        if (bit_q == DATA_LAST) begin
                            bit_d       = '0;
                            stop_bad_d  = 1'b0;
                            stop_all0_d = 1'b1;
                            state_d     = HAS_PAR ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                ST_PARITY: begin
                    if (tick_q == TICK_END) begin
                        tick_d    = '0;
                        bit_d     = '0;
                        par_bit_d = rxs;
                        par_err_d = parity_mismatch(^{buf_q, rxs}, ODD_MODE);
                        state_d   = ST_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (tick_q == TICK_END) begin
                        tick_d = '0;
                        if (bit_q == STOP_LAST) begin
                            data_d  = buf_q;
                            done_d  = 1'b1;
                            perr_d  = HAS_PAR & par_err_q;
                            ferr_d  = stop_bad_now;
                            brk_d   = (buf_q == '0) && (!HAS_PAR || !par_bit_q) && stop_all0_now;
                            // A low stop sample may be a held break: wait for idle before re-arming.
                            state_d = rxs ? ST_IDLE : ST_WAIT_HIGH;
                        end else begin
                            bit_d       = bit_q + 1'b1;
                            stop_bad_d  = stop_bad_now;
                            stop_all0_d = stop_all0_now;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                ST_WAIT_HIGH: begin
                    if (rxs) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            endcase
        end
    end

    // State, counters, shift buffer and output flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            buf_q       <= '0;
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
            stop_bad_q  <= 1'b0;
            stop_all0_q <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            brk_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            buf_q       <= buf_d;
            par_bit_q   <= par_bit_d;
            par_err_q   <= par_err_d;
            stop_bad_q  <= stop_bad_d;
            stop_all0_q <= stop_all0_d;
            data_q      <= data_d;
            done_q      <= done_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            brk_q       <= brk_d;
        end
    end

    assign rx_data     = data_q;
    assign rx_doneTick = done_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign break_det   = brk_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, 8E1, 7N2) sharing clock,
// s_tick (every 4 clk, OVERSAMPLE=16 -> 64 clk per bit) and reset.
module tb_uart_rx_cfg;

    localparam int BIT_CLK = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_tick = 1'b0;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;
    logic rx_c = 1'b1;

    logic [7:0] data_a, data_b;
    logic [6:0] data_c;
    logic done_a, perr_a, ferr_a, brk_a, busy_a;
    logic done_b, perr_b, ferr_b, brk_b, busy_b;
    logic done_c, perr_c, ferr_c, brk_c, busy_c;

    int checks = 0;
    int errors = 0;
    int cnt_a = 0;
    int cnt_b = 0;
    int cnt_c = 0;

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY_EN(0),
                  .PARITY_ODD(0), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .rx(rx_a),
        .rx_data(data_a), .rx_doneTick(done_a), .parity_err(perr_a),
        .frame_err(ferr_a), .break_det(brk_a), .busy(busy_a));

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY_EN(1),
                  .PARITY_ODD(0), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .rx(rx_b),
        .rx_data(data_b), .rx_doneTick(done_b), .parity_err(perr_b),
        .frame_err(ferr_b), .break_det(brk_b), .busy(busy_b));

    uart_rx_cfg #(.DATA_BITS(7), .OVERSAMPLE(16), .STOP_BITS(2), .PARITY_EN(0),
                  .PARITY_ODD(0), .SYNC_STAGES(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .rx(rx_c),
        .rx_data(data_c), .rx_doneTick(done_c), .parity_err(perr_c),
        .frame_err(ferr_c), .break_det(brk_c), .busy(busy_c));

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    // Count clocks with the done pulse high; a correct 1-clk pulse adds exactly 1 per frame.
    always @(negedge clk) begin
        if (done_a) cnt_a <= cnt_a + 1;
        if (done_b) cnt_b <= cnt_b + 1;
        if (done_c) cnt_c <= cnt_c + 1;
    end

    task automatic set_rx(input int which, input logic v);
        case (which)
            0: rx_a = v;
            1: rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    // Send n bits LSB first on one line, each a full bit period, then idle high for 2 bits.
    task automatic send_bits(input int which, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_rx(which, bits[i]);
            repeat (BIT_CLK) @(negedge clk);
        end
        set_rx(which, 1'b1);
        repeat (2 * BIT_CLK) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (data_a !== 8'h00 || done_a !== 1'b0 || perr_a !== 1'b0 || ferr_a !== 1'b0 ||
            brk_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: data=%h done=%b perr=%b ferr=%b brk=%b busy=%b, want all 0",
                     data_a, done_a, perr_a, ferr_a, brk_a, busy_a);
        end
        checks++;
        if (data_c !== 7'h00 || busy_c !== 1'b0 || busy_b !== 1'b0 || data_b !== 8'h00) begin
            errors++;
            $display("FAIL reset_bc: data_b=%h data_c=%h busy_b=%b busy_c=%b, want 0",
                     data_b, data_c, busy_b, busy_c);
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_8n1();
        int c0;
        c0 = cnt_a;
        send_bits(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
        checks++;
        if (cnt_a - c0 !== 1) begin
            errors++;
            $display("FAIL 8n1_pulses: got %0d want 1", cnt_a - c0);
        end
        checks++;
        if (data_a !== 8'hA5) begin
            errors++;
            $display("FAIL 8n1_data: got %h want a5", data_a);
        end
        checks++;
        if (perr_a !== 1'b0 || ferr_a !== 1'b0 || brk_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL 8n1_flags: perr=%b ferr=%b brk=%b busy=%b want 0 0 0 0",
                     perr_a, ferr_a, brk_a, busy_a);
        end
    endtask

    task automatic test_frame_err();
        int c0;
        c0 = cnt_a;
        send_bits(0, {6'b0, 1'b0, 8'h3C, 1'b0}, 10);
        checks++;
        if (cnt_a - c0 !== 1 || data_a !== 8'h3C) begin
            errors++;
            $display("FAIL ferr_data: pulses=%0d data=%h want 1 3c", cnt_a - c0, data_a);
        end
        checks++;
        if (ferr_a !== 1'b1 || brk_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL ferr_flags: ferr=%b brk=%b busy=%b want 1 0 0", ferr_a, brk_a, busy_a);
        end
    endtask

    task automatic test_false_start();
        int c0;
        c0 = cnt_a;
        rx_a = 1'b0;
        repeat (5 * 4) @(negedge clk);
        rx_a = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        checks++;
        if (cnt_a - c0 !== 0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL false_start: pulses=%0d busy=%b want 0 0", cnt_a - c0, busy_a);
        end
        checks++;
        if (data_a !== 8'h3C || ferr_a !== 1'b1 || brk_a !== 1'b0) begin
            errors++;
            $display("FAIL false_start_hold: data=%h ferr=%b brk=%b want 3c 1 0",
                     data_a, ferr_a, brk_a);
        end
    endtask

    task automatic test_break();
        int c0;
        c0 = cnt_a;
        rx_a = 1'b0;
        repeat (20 * BIT_CLK) @(negedge clk);
        checks++;
        if (busy_a !== 1'b1 || cnt_a - c0 !== 1) begin
            errors++;
            $display("FAIL break_mid: busy=%b pulses=%0d want 1 1", busy_a, cnt_a - c0);
        end
        repeat (20 * BIT_CLK) @(negedge clk);
        rx_a = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        checks++;
        if (cnt_a - c0 !== 1 || data_a !== 8'h00) begin
            errors++;
            $display("FAIL break_frame: pulses=%0d data=%h want 1 00", cnt_a - c0, data_a);
        end
        checks++;
        if (ferr_a !== 1'b1 || brk_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL break_flags: ferr=%b brk=%b busy=%b want 1 1 0", ferr_a, brk_a, busy_a);
        end
        send_bits(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
        checks++;
        if (cnt_a - c0 !== 2 || data_a !== 8'h5A || perr_a !== 1'b0 || ferr_a !== 1'b0 ||
            brk_a !== 1'b0) begin
            errors++;
            $display("FAIL after_break: pulses=%0d data=%h perr=%b ferr=%b brk=%b want 2 5a 0 0 0",
                     cnt_a - c0, data_a, perr_a, ferr_a, brk_a);
        end
    endtask

    task automatic test_parity();
        int c0;
        c0 = cnt_b;
        send_bits(1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        checks++;
        if (cnt_b - c0 !== 1 || data_b !== 8'h07 || perr_b !== 1'b1 || ferr_b !== 1'b0) begin
            errors++;
            $display("FAIL parity_bad: pulses=%0d data=%h perr=%b ferr=%b want 1 07 1 0",
                     cnt_b - c0, data_b, perr_b, ferr_b);
        end
        send_bits(1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
        checks++;
        if (cnt_b - c0 !== 2 || data_b !== 8'h07 || perr_b !== 1'b0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL parity_good: pulses=%0d data=%h perr=%b busy=%b want 2 07 0 0",
                     cnt_b - c0, data_b, perr_b, busy_b);
        end
    endtask

    task automatic test_7n2();
        int c0;
        c0 = cnt_c;
        send_bits(2, {6'b0, 2'b11, 7'h55, 1'b0}, 10);
        checks++;
        if (cnt_c - c0 !== 1 || data_c !== 7'h55 || ferr_c !== 1'b0 || brk_c !== 1'b0) begin
            errors++;
            $display("FAIL 7n2_data: pulses=%0d data=%h ferr=%b brk=%b want 1 55 0 0",
                     cnt_c - c0, data_c, ferr_c, brk_c);
        end
        // Second stop bit low must still flag a framing error.
        send_bits(2, {6'b0, 2'b01, 7'h2A, 1'b0}, 10);
        checks++;
        if (cnt_c - c0 !== 2 || data_c !== 7'h2A || ferr_c !== 1'b1 || busy_c !== 1'b0) begin
            errors++;
            $display("FAIL 7n2_stop2: pulses=%0d data=%h ferr=%b busy=%b want 2 2a 1 0",
                     cnt_c - c0, data_c, ferr_c, busy_c);
        end
    endtask

    task automatic test_reset_midframe();
        int c0;
        logic [7:0] fr;
        c0 = cnt_c;
        fr = {7'h7F, 1'b0};
        for (int i = 0; i < 4; i++) begin
            rx_c = fr[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rx_c = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (busy_c !== 1'b1) begin
            errors++;
            $display("FAIL midframe_busy: got %b want 1", busy_c);
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (data_c !== 7'h00 || ferr_c !== 1'b0 || busy_c !== 1'b0 || done_c !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: data=%h ferr=%b busy=%b done=%b want 0 0 0 0",
                     data_c, ferr_c, busy_c, done_c);
        end
        repeat (8 * BIT_CLK) @(negedge clk);
        checks++;
        if (cnt_c - c0 !== 0 || data_c !== 7'h00) begin
            errors++;
            $display("FAIL midframe_nopulse: pulses=%0d data=%h want 0 00", cnt_c - c0, data_c);
        end
        send_bits(2, {6'b0, 2'b11, 7'h2A, 1'b0}, 10);
        checks++;
        if (cnt_c - c0 !== 1 || data_c !== 7'h2A || ferr_c !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: pulses=%0d data=%h ferr=%b want 1 2a 0",
                     cnt_c - c0, data_c, ferr_c);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_frame_err();
        test_false_start();
        test_break();
        test_parity();
        test_7n2();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
